// File: rtl/mod_counter_ar_pkg.sv
// rtl/mod_counter_ar_pkg.sv - shared types and constants for the time-digit counter
// Purpose: auto-repeat FSM state type, default button timing for a 50 MHz
//          clock, and the standard modulos of the clock datapath stages.
// Ports:   none (package).
// Config:  MOD_COUNTER_BCD_OUT_EN is not used here.
package mod_counter_ar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  // Button timing at 50 MHz: 1 s before auto-repeat, then 5 steps per second.
  localparam int HOLD_CYCLES_50MHZ   = 50_000_000;
  localparam int REPEAT_CYCLES_50MHZ = 10_000_000;

  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;

endpackage

// File: rtl/mod_counter_ar_if.sv
// rtl/mod_counter_ar_if.sv - control/status bundle of one counter stage
// Purpose: groups the stage controls (set mode, buttons, tick, load) and the
//          stage outputs (count, carry/borrow, at_zero, optional BCD digits).
// Ports:   master drives ctrl_set, inc, dec, tick_in, count_down, load,
//          load_val and observes count, carry_out, borrow_out, at_zero,
//          bcd_tens/bcd_ones; slave is the counter side.
// Config:  MOD_COUNTER_BCD_OUT_EN adds bcd_tens/bcd_ones.
interface mod_counter_ar_if #(
  parameter int WIDTH = 6
);

  logic             ctrl_set;
  logic             inc;
  logic             dec;
  logic             tick_in;
  logic             count_down;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             carry_out;
  logic             borrow_out;
  logic             at_zero;
`ifdef MOD_COUNTER_BCD_OUT_EN
  logic [3:0]       bcd_tens;
  logic [3:0]       bcd_ones;
`endif

  modport master (
    output ctrl_set, inc, dec, tick_in, count_down, load, load_val,
`ifdef MOD_COUNTER_BCD_OUT_EN
    input  bcd_tens, bcd_ones,
`endif
    input  count, carry_out, borrow_out, at_zero
  );

  modport slave (
    input  ctrl_set, inc, dec, tick_in, count_down, load, load_val,
`ifdef MOD_COUNTER_BCD_OUT_EN
    output bcd_tens, bcd_ones,
`endif
    output count, carry_out, borrow_out, at_zero
  );

endinterface

// File: rtl/mod_counter_ar_autorepeat.sv
// rtl/mod_counter_ar_autorepeat.sv - press/hold/repeat step generator for one button
// Purpose: one step on the press, one more after HOLD_CYCLES of holding, then
//          one every REPEAT_CYCLES while the button stays down.
// Ports:   clk, rst_n (async, active-low); en (set mode and not blocked);
//          btn (level, debounced); step (one-cycle pulse, combinational).
// Config:  MOD_COUNTER_BCD_OUT_EN is not used here.
module btn_autorepeat
  import mod_counter_ar_pkg::*;
#(
  parameter int HOLD_CYCLES   = HOLD_CYCLES_50MHZ,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_50MHZ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic btn,
  output logic step
);

  localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

  rpt_state_t    r_state;
  rpt_state_t    w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic          r_btn_q;
  logic          w_rise;

  // r_btn_q resets high so a button held through reset is not seen as a press.
  assign w_rise = btn & ~r_btn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_btn_q <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_btn_q <= btn;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    step        = 1'b0;
    if (!en || !btn) begin
      w_state_nxt = IDLE;
      w_timer_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            step        = 1'b1;
            w_state_nxt = HOLD;
            w_timer_nxt = '0;
          end
        end
        HOLD: begin
          if (r_timer == HOLD_LAST) begin
            step        = 1'b1;
            w_state_nxt = REPEAT;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
        REPEAT: begin
          if (r_timer == REPEAT_LAST) begin
            step        = 1'b1;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mod_counter_ar.sv
// rtl/mod_counter_ar.sv - modulo-N up/down time digit with load and button auto-repeat
// Purpose: one cascadable stage of the clock datapath (sec/min/hour/...).
// Ports:   clk, rst_n (async, active-low); bus (slave): ctrl_set, inc, dec,
//          tick_in, count_down, load, load_val in; count, at_zero (registered),
//          carry_out, borrow_out (combinational), bcd_tens/bcd_ones out.
// Config:  MOD_COUNTER_BCD_OUT_EN enables registered BCD digits (MODULO <= 100).
module mod_counter_ar
  import mod_counter_ar_pkg::*;
#(
  parameter int MODULO        = SEC_MOD,
  parameter int WIDTH         = $clog2(MODULO),
  parameter int HOLD_CYCLES   = HOLD_CYCLES_50MHZ,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_50MHZ
) (
  input  logic            clk,
  input  logic            rst_n,
  mod_counter_ar_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_count_inc;
  logic [WIDTH-1:0] w_count_dec;
  logic             r_at_zero;
  logic             r_block;
  logic             w_both;
  logic             w_en;
  logic             w_inc_step;
  logic             w_dec_step;
  logic             w_tick;

  // Both buttons down locks out stepping until both are back up, so releasing
  // just one of them never produces a stray step.
  assign w_both = bus.inc & bus.dec;
  assign w_en   = bus.ctrl_set & ~w_both & ~r_block;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_block <= 1'b0;
    end else if (w_both) begin
      r_block <= 1'b1;
    end else if (!bus.inc && !bus.dec) begin
      r_block <= 1'b0;
    end
  end

  btn_autorepeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_inc_rpt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (w_en),
    .btn  (bus.inc),
    .step (w_inc_step)
  );

  btn_autorepeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_dec_rpt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (w_en),
    .btn  (bus.dec),
    .step (w_dec_step)
  );

  assign w_tick      = bus.tick_in & ~bus.ctrl_set;
  assign w_count_inc = (r_count == MAX_VAL) ? '0 : r_count + WIDTH'(1);
  assign w_count_dec = (r_count == '0) ? MAX_VAL : r_count - WIDTH'(1);

  always_comb begin
    w_count_nxt = r_count;
    if (bus.load) begin
      w_count_nxt = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
    end else if (w_inc_step) begin
      w_count_nxt = w_count_inc;
    end else if (w_dec_step) begin
      w_count_nxt = w_count_dec;
    end else if (w_tick) begin
      w_count_nxt = bus.count_down ? w_count_dec : w_count_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_at_zero <= 1'b1;
    end else begin
      r_count   <= w_count_nxt;
      r_at_zero <= (w_count_nxt == '0);
    end
  end

  assign bus.count      = r_count;
  assign bus.at_zero    = r_at_zero;
  assign bus.carry_out  = w_tick & ~bus.load & ~bus.count_down & (r_count == MAX_VAL);
  assign bus.borrow_out = w_tick & ~bus.load & bus.count_down & (r_count == '0);

`ifdef MOD_COUNTER_BCD_OUT_EN
  logic [3:0] r_bcd_tens;
  logic [3:0] r_bcd_ones;

  // Digits come from the next count so they change on the same edge as count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd_tens <= '0;
      r_bcd_ones <= '0;
    end else begin
      r_bcd_tens <= 4'(int'(w_count_nxt) / 10);
      r_bcd_ones <= 4'(int'(w_count_nxt) % 10);
    end
  end

  assign bus.bcd_tens = r_bcd_tens;
  assign bus.bcd_ones = r_bcd_ones;
`endif

endmodule

// File: tb/tb_mod_counter_ar.sv
// tb/tb_mod_counter_ar.sv - self-checking bench for mod_counter_ar (MODULO=60, HOLD=4, REPEAT=2)
module tb_mod_counter_ar;

  localparam int MODULO = 60;
  localparam int WIDTH  = 7;
  localparam int HOLD   = 4;
  localparam int REP    = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   model  = 0;

  always #5 clk = ~clk;

  mod_counter_ar_if #(.WIDTH(WIDTH)) bus ();

  mod_counter_ar #(
    .MODULO       (MODULO),
    .WIDTH        (WIDTH),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ctrl_set   = 1'b0;
    bus.inc        = 1'b0;
    bus.dec        = 1'b0;
    bus.tick_in    = 1'b0;
    bus.count_down = 1'b0;
    bus.load       = 1'b0;
    bus.load_val   = '0;
  endtask

  function automatic int ref_inc(int c);
    return (c + 1) % MODULO;
  endfunction

  function automatic int ref_dec(int c);
    return (c + MODULO - 1) % MODULO;
  endfunction

  // Steps happen on the press, after HOLD cycles, then every REP cycles.
  function automatic bit is_step(int k);
    return (k == 0) || (k >= HOLD && ((k - HOLD) % REP) == 0);
  endfunction

  task automatic do_load(int v);
    bus.load     = 1'b1;
    bus.load_val = WIDTH'(v);
    cyc();
    bus.load     = 1'b0;
    model        = (v > MODULO - 1) ? MODULO - 1 : v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) cyc();
    checks++;
    if (bus.count !== WIDTH'(0)) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", bus.count);
    end
    checks++;
    if (bus.at_zero !== 1'b1) begin
      errors++; $display("FAIL reset_at_zero: got %b expected 1", bus.at_zero);
    end
`ifdef MOD_COUNTER_BCD_OUT_EN
    checks++;
    if (bus.bcd_tens !== 4'd0 || bus.bcd_ones !== 4'd0) begin
      errors++; $display("FAIL reset_bcd: got %0d%0d expected 00", bus.bcd_tens, bus.bcd_ones);
    end
`endif
    rst_n = 1'b1;
    cyc();
    model = 0;
  endtask

  task automatic test_carry_wrap();
    do_load(59);
    checks++;
    if (bus.count !== WIDTH'(59)) begin
      errors++; $display("FAIL load_59: got %0d expected 59", bus.count);
    end
    bus.tick_in = 1'b1;
    bus.count_down = 1'b0;
    #1;
    checks++;
    if (bus.carry_out !== 1'b1 || bus.borrow_out !== 1'b0) begin
      errors++; $display("FAIL carry_pulse: got c=%b b=%b expected c=1 b=0", bus.carry_out, bus.borrow_out);
    end
    cyc();
    bus.tick_in = 1'b0;
    checks++;
    if (bus.count !== WIDTH'(0) || bus.at_zero !== 1'b1) begin
      errors++; $display("FAIL carry_wrap: got count=%0d z=%b expected 0 z=1", bus.count, bus.at_zero);
    end
  endtask

  task automatic test_borrow_wrap();
    bus.tick_in = 1'b1;
    bus.count_down = 1'b1;
    #1;
    checks++;
    if (bus.borrow_out !== 1'b1 || bus.carry_out !== 1'b0) begin
      errors++; $display("FAIL borrow_pulse: got b=%b c=%b expected b=1 c=0", bus.borrow_out, bus.carry_out);
    end
    cyc();
    bus.tick_in = 1'b0;
    bus.count_down = 1'b0;
    checks++;
    if (bus.count !== WIDTH'(59) || bus.at_zero !== 1'b0) begin
      errors++; $display("FAIL borrow_wrap: got count=%0d z=%b expected 59 z=0", bus.count, bus.at_zero);
    end
  endtask

  task automatic test_load_clamp();
    bus.load = 1'b1;
    bus.load_val = WIDTH'(75);
    bus.tick_in = 1'b1;
    #1;
    checks++;
    if (bus.carry_out !== 1'b0) begin
      errors++; $display("FAIL load_no_carry: got %b expected 0", bus.carry_out);
    end
    cyc();
    bus.load = 1'b0;
    bus.tick_in = 1'b0;
    checks++;
    if (bus.count !== WIDTH'(59)) begin
      errors++; $display("FAIL load_clamp: got %0d expected 59", bus.count);
    end
    do_load(47);
    checks++;
    if (bus.count !== WIDTH'(47)) begin
      errors++; $display("FAIL load_47: got %0d expected 47", bus.count);
    end
`ifdef MOD_COUNTER_BCD_OUT_EN
    checks++;
    if (bus.bcd_tens !== 4'd4 || bus.bcd_ones !== 4'd7) begin
      errors++; $display("FAIL bcd_47: got %0d,%0d expected 4,7", bus.bcd_tens, bus.bcd_ones);
    end
`endif
  endtask

  task automatic test_autorepeat();
    do_load(58);
    bus.ctrl_set = 1'b1;
    bus.inc = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.tick_in = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (bus.carry_out !== 1'b0 || bus.borrow_out !== 1'b0) begin
        errors++; $display("FAIL rpt_no_carry k=%0d: got c=%b b=%b expected 0 0", k, bus.carry_out, bus.borrow_out);
      end
      cyc();
      if (is_step(k)) model = ref_inc(model);
      checks++;
      if (bus.count !== WIDTH'(model)) begin
        errors++; $display("FAIL rpt_count k=%0d: got %0d expected %0d", k, bus.count, model);
      end
    end
    bus.inc = 1'b0;
    bus.tick_in = 1'b0;
    cyc();
    checks++;
    if (bus.count !== WIDTH'(2)) begin
      errors++; $display("FAIL rpt_final: got %0d expected 2", bus.count);
    end
    bus.ctrl_set = 1'b0;
  endtask

  task automatic test_both_buttons();
    bus.ctrl_set = 1'b1;
    bus.inc = 1'b1;
    bus.dec = 1'b1;
    repeat (3) cyc();
    checks++;
    if (bus.count !== WIDTH'(model)) begin
      errors++; $display("FAIL both_held: got %0d expected %0d", bus.count, model);
    end
    bus.dec = 1'b0;
    repeat (HOLD + 2) cyc();
    checks++;
    if (bus.count !== WIDTH'(model)) begin
      errors++; $display("FAIL dec_released: got %0d expected %0d", bus.count, model);
    end
    bus.inc = 1'b0;
    cyc();
    bus.inc = 1'b1;
    cyc();
    model = ref_inc(model);
    checks++;
    if (bus.count !== WIDTH'(model)) begin
      errors++; $display("FAIL inc_repress: got %0d expected %0d", bus.count, model);
    end
    bus.inc = 1'b0;
    cyc();
    bus.ctrl_set = 1'b0;
  endtask

  task automatic test_random_ticks();
    bit exp_c, exp_b;
    int lv;
    for (int i = 0; i < 300; i++) begin
      bus.tick_in    = 1'($urandom_range(0, 1));
      bus.count_down = 1'($urandom_range(0, 1));
      bus.load       = ($urandom_range(0, 9) == 0);
      lv             = int'($urandom_range(0, 127));
      bus.load_val   = WIDTH'(lv);
      exp_c = bus.tick_in && !bus.load && !bus.count_down && model == MODULO - 1;
      exp_b = bus.tick_in && !bus.load && bus.count_down && model == 0;
      #1;
      checks++;
      if (bus.carry_out !== exp_c || bus.borrow_out !== exp_b) begin
        errors++; $display("FAIL rand_cb i=%0d: got c=%b b=%b expected c=%b b=%b", i, bus.carry_out, bus.borrow_out, exp_c, exp_b);
      end
      if (bus.load) model = (lv > MODULO - 1) ? MODULO - 1 : lv;
      else if (bus.tick_in) model = bus.count_down ? ref_dec(model) : ref_inc(model);
      cyc();
      checks++;
      if (bus.count !== WIDTH'(model) || bus.at_zero !== (model == 0)) begin
        errors++; $display("FAIL rand_count i=%0d: got %0d z=%b expected %0d", i, bus.count, bus.at_zero, model);
      end
`ifdef MOD_COUNTER_BCD_OUT_EN
      checks++;
      if (bus.bcd_tens !== 4'(model / 10) || bus.bcd_ones !== 4'(model % 10)) begin
        errors++; $display("FAIL rand_bcd i=%0d: got %0d,%0d expected %0d", i, bus.bcd_tens, bus.bcd_ones, model);
      end
`endif
    end
    idle_inputs();
  endtask

  task automatic test_random_hold();
    int n;
    bit up;
    bus.ctrl_set = 1'b1;
    for (int i = 0; i < 8; i++) begin
      up = 1'($urandom_range(0, 1));
      n  = int'($urandom_range(1, 14));
      bus.inc = up;
      bus.dec = !up;
      repeat (n) cyc();
      bus.inc = 1'b0;
      bus.dec = 1'b0;
      cyc();
      for (int k = 0; k < n; k++)
        if (is_step(k)) model = up ? ref_inc(model) : ref_dec(model);
      checks++;
      if (bus.count !== WIDTH'(model)) begin
        errors++; $display("FAIL hold i=%0d up=%b n=%0d: got %0d expected %0d", i, up, n, bus.count, model);
      end
    end
    bus.ctrl_set = 1'b0;
  endtask

  task automatic test_reset_mid_repeat();
    do_load(30);
    bus.ctrl_set = 1'b1;
    bus.inc = 1'b1;
    repeat (HOLD + 4) cyc();
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.count !== WIDTH'(0) || bus.at_zero !== 1'b1) begin
      errors++; $display("FAIL async_reset: got %0d z=%b expected 0 z=1", bus.count, bus.at_zero);
    end
    cyc();
    rst_n = 1'b1;
    repeat (HOLD + 3) cyc();
    checks++;
    if (bus.count !== WIDTH'(0)) begin
      errors++; $display("FAIL held_through_reset: got %0d expected 0", bus.count);
    end
    bus.inc = 1'b0;
    cyc();
    bus.inc = 1'b1;
    cyc();
    checks++;
    if (bus.count !== WIDTH'(1)) begin
      errors++; $display("FAIL press_after_reset: got %0d expected 1", bus.count);
    end
    idle_inputs();
    cyc();
    model = 1;
  endtask

  initial begin
    test_reset();
    test_carry_wrap();
    test_borrow_wrap();
    test_load_clamp();
    test_autorepeat();
    test_both_buttons();
    test_random_ticks();
    test_random_hold();
    test_reset_mid_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
